ctrl_fsm: RTL and testbench

- Multicycle control sequencer for the 16-bit CR16-style datapath; sits directly upstream of the program counter.
- Fetches each instruction through a ready/valid memory handshake and holds it in an internal instruction register.
- Decodes the instruction and evaluates branch/jump conditions against the PSR flags.
- Drives the PC stage's enable, next-PC select and sign-extended displacement, plus register-file and data-memory strobes.

---
 rtl/ctrl_fsm_if.sv | 25 ++
 rtl/ctrl_fsm.sv | 68 ++++++
 tb/tb_ctrl_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: fetch/memory handshake and PC-stage control bundle for ctrl_fsm
interface ctrl_fsm_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] branch_disp;
  logic              instr_valid;
  logic              mem_rdy;
  logic [4:0]        flags;
  logic              instr_req;
  logic              PCe;
  logic [1:0]        PCsrc;
  logic              rf_we;
  logic              link_sel;
  logic              mem_req;
  logic              mem_we;
  logic [2:0]        state;
  modport master(
    input  instr, instr_valid, mem_rdy, flags,
    output instr_req, ir, PCe, PCsrc, branch_disp, rf_we, link_sel, mem_req, mem_we, state
  );
  modport slave(
    output instr, instr_valid, mem_rdy, flags,
    input  instr_req, ir, PCe, PCsrc, branch_disp, rf_we, link_sel, mem_req, mem_we, state
  );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle fetch/decode/exec/mem sequencer driving the PC stage, register file and data memory
module ctrl_fsm #(parameter int DATA_W = 16) (
  input logic        clk,
  input logic        rst,
  ctrl_fsm_if.master b
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3} state_t;
  state_t            st;
  logic [DATA_W-1:0] ir;
  logic [3:0]        op, cnd, ext;
  logic              is_b, is_j, is_jal, is_ld, is_st, is_cmp, is_alu, base, ok, ex, mm;
  assign op  = ir[15:12];
  assign cnd = ir[11:8];
  assign ext = ir[7:4];
  always_comb begin
    is_b   = op == 4'b1100;
    is_j   = op == 4'b0100 && ext == 4'b1100;
    is_jal = op == 4'b0100 && ext == 4'b1000;
    is_ld  = op == 4'b0100 && ext == 4'b0000;
    is_st  = op == 4'b0100 && ext == 4'b0100;
    is_cmp = (op == 4'b0000 && ext == 4'b1011) || op == 4'b1011;
    is_alu = !(is_b || is_j || is_jal || is_ld || is_st);
  end
  // odd condition codes are the complement of the preceding even one; 1110/1111 are always/never
  always_comb begin
    base = 1'b1;
    case (cnd[3:1])
      3'd0: base = b.flags[1];
      3'd1: base = b.flags[4];
      3'd2: base = b.flags[3];
      3'd3: base = b.flags[0];
      3'd4: base = b.flags[2];
      3'd5: base = !b.flags[3] && !b.flags[1];
      3'd6: base = !b.flags[0] && !b.flags[1];
      default: base = 1'b1;
    endcase
    ok = base ^ cnd[0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= FETCH;
      ir <= '0;
    end else begin
      case (st)
        FETCH: if (b.instr_valid) begin
          ir <= b.instr;
          st <= DECODE;
        end
        DECODE: st <= EXEC;
        EXEC:   st <= (is_ld || is_st) ? MEM : FETCH;
        MEM:    st <= b.mem_rdy ? FETCH : MEM;
        default: st <= FETCH;
      endcase
    end
  end
  assign ex            = st == EXEC;
  assign mm            = st == MEM;
  assign b.state       = st;
  assign b.ir          = ir;
  assign b.branch_disp = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign b.instr_req   = st == FETCH;
  assign b.PCe         = (ex && !(is_ld || is_st)) || (mm && b.mem_rdy);
  assign b.PCsrc       = !ex ? 2'b00 : (is_b && ok) ? 2'b01 : ((is_j && ok) || is_jal) ? 2'b10 : 2'b00;
  assign b.rf_we       = (ex && ((is_alu && !is_cmp) || is_jal)) || (mm && b.mem_rdy && is_ld);
  assign b.link_sel    = ex && is_jal;
  assign b.mem_req     = mm;
  assign b.mem_we      = mm && is_st;
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized and directed checks of ctrl_fsm against a per-instruction behavioural model
module tb_ctrl_fsm;
  logic clk = 0;
  logic rst = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;
  ctrl_fsm_if #(.DATA_W(16)) b();
  ctrl_fsm #(.DATA_W(16)) dut(.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;

  localparam int ALU = 0, CMP = 1, BR = 2, JC = 3, JAL = 4, LD = 5, ST = 6;
  int          m_ph;
  logic [15:0] m_ir;

  function automatic int kind(input logic [15:0] w);
    if (w[15:12] == 4'hC) return BR;
    if (w[15:12] == 4'h4 && w[7:4] == 4'hC) return JC;
    if (w[15:12] == 4'h4 && w[7:4] == 4'h8) return JAL;
    if (w[15:12] == 4'h4 && w[7:4] == 4'h0) return LD;
    if (w[15:12] == 4'h4 && w[7:4] == 4'h4) return ST;
    if ((w[15:12] == 4'h0 && w[7:4] == 4'hB) || w[15:12] == 4'hB) return CMP;
    return ALU;
  endfunction

  function automatic bit cond(input logic [3:0] c, input logic [4:0] f);
    bit cf = f[4], lf = f[3], ff = f[2], zf = f[1], nf = f[0];
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= 0;
      m_ir <= 16'h0000;
    end else if (m_ph == 0) begin
      if (b.instr_valid) begin
        m_ir <= b.instr;
        m_ph <= 1;
      end
    end else if (m_ph == 1) m_ph <= 2;
    else if (m_ph == 2) m_ph <= (kind(m_ir) == LD || kind(m_ir) == ST) ? 3 : 0;
    else m_ph <= b.mem_rdy ? 0 : 3;
  end

  always @(negedge clk) if (chk_en) begin
    automatic int k = kind(m_ir);
    automatic bit t = cond(m_ir[11:8], b.flags);
    automatic int d = m_ir[7:0];
    automatic bit pce = 0, rf = 0, lk = 0;
    automatic logic [1:0] src = 2'b00;
    if (d > 127) d -= 256;
    if (m_ph == 2 && k != LD && k != ST) begin
      pce = 1;
      rf  = (k == ALU) || (k == JAL);
      lk  = k == JAL;
      src = (k == BR && t) ? 2'b01 : ((k == JC && t) || k == JAL) ? 2'b10 : 2'b00;
    end
    if (m_ph == 3 && b.mem_rdy) begin
      pce = 1;
      rf  = k == LD;
    end
    chk("state", 16'(b.state), 16'(m_ph));
    chk("ir", b.ir, m_ir);
    chk("branch_disp", b.branch_disp, 16'(d));
    chk("instr_req", 16'(b.instr_req), 16'(m_ph == 0));
    chk("PCe", 16'(b.PCe), 16'(pce));
    chk("PCsrc", 16'(b.PCsrc), 16'(src));
    chk("rf_we", 16'(b.rf_we), 16'(rf));
    chk("link_sel", 16'(b.link_sel), 16'(lk));
    chk("mem_req", 16'(b.mem_req), 16'(m_ph == 3));
    chk("mem_we", 16'(b.mem_we), 16'(m_ph == 3 && k == ST));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_exec(input logic [15:0] w, input logic [4:0] f);
    b.instr = w;
    b.instr_valid = 1;
    b.flags = f;
    step();
    b.instr_valid = 0;
    @(negedge clk);
    chk("dec_state", 16'(b.state), 16'd1);
    chk("dec_PCe", 16'(b.PCe), 16'd0);
    step();
    @(negedge clk);
  endtask

  logic [15:0] pool [9] = '{16'h0521, 16'hC0FE, 16'h4EC3, 16'h4FC3, 16'h4283,
                            16'h4102, 16'h4142, 16'h0B12, 16'hB123};

  initial begin
    b.instr = 0;
    b.instr_valid = 0;
    b.mem_rdy = 0;
    b.flags = 0;
    chk_en = 1;
    repeat (2) step();
    chk("rst_state", 16'(b.state), 16'd0);
    chk("rst_ir", b.ir, 16'h0000);
    chk("rst_instr_req", 16'(b.instr_req), 16'd1);
    chk("rst_PCe", 16'(b.PCe), 16'd0);
    rst = 1;
    @(negedge clk);
    chk("add_fetch", 16'(b.state), 16'd0);
    step();
    to_exec(16'h0521, 5'b0);
    chk("add_exec", {b.state, b.PCe, b.rf_we, b.PCsrc}, {3'd2, 1'b1, 1'b1, 2'b00});
    step();
    @(negedge clk);
    chk("add_back", 16'(b.state), 16'd0);
    step();
    to_exec(16'hC0FE, 5'b00010);
    chk("bz_taken", {b.PCe, b.PCsrc}, {1'b1, 2'b01});
    chk("bz_disp", b.branch_disp, 16'hFFFE);
    step();
    to_exec(16'hC0FE, 5'b00000);
    chk("bz_not", {b.PCe, b.PCsrc}, {1'b1, 2'b00});
    step();
    to_exec(16'h4EC3, 5'b0);
    chk("j_uc", 16'(b.PCsrc), 16'd2);
    step();
    to_exec(16'h4FC3, 5'b11111);
    chk("j_never", 16'(b.PCsrc), 16'd0);
    step();
    to_exec(16'h4283, 5'b0);
    chk("jal", {b.rf_we, b.link_sel, b.PCsrc}, {1'b1, 1'b1, 2'b10});
    step();
    for (int s = 0; s < 2; s++) begin
      to_exec(s == 0 ? 16'h4102 : 16'h4142, 5'b0);
      chk("ldst_exec_PCe", 16'(b.PCe), 16'd0);
      step();
      for (int i = 0; i < 4; i++) begin
        b.mem_rdy = i == 3;
        @(negedge clk);
        chk("mem_hold", {b.state, b.mem_req, b.mem_we}, {3'd3, 1'b1, 1'(s)});
        chk("mem_rf_pce", {b.rf_we, b.PCe}, {1'(s == 0 && i == 3), 1'(i == 3)});
        step();
      end
      b.mem_rdy = 0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall", {b.state, b.instr_req, b.PCe}, {3'd0, 1'b1, 1'b0});
      chk("stall_ir", b.ir, 16'h4142);
      step();
    end
    to_exec(16'h4102, 5'b0);
    step();
    chk("pre_rst_mem", 16'(b.state), 16'd3);
    rst = 0;
    #1;
    chk("arst", {b.state, b.mem_req, b.instr_req}, {3'd0, 1'b0, 1'b1});
    chk("arst_ir", b.ir, 16'h0000);
    step();
    rst = 1;
    @(negedge clk);
    chk("post_rst", {13'd0, b.state}, 16'd0);
    step();
    for (int c = 0; c < 3000; c++) begin
      b.instr = $urandom_range(0, 3) == 0 ? 16'($urandom) : pool[$urandom_range(0, 8)];
      b.instr_valid = $urandom_range(0, 9) < 7;
      b.mem_rdy = $urandom_range(0, 1) == 1;
      b.flags = 5'($urandom);
      rst = $urandom_range(0, 199) != 0;
      step();
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
